// File: rtl/int_ctrl.sv
// int_ctrl: coprocessor-0 style interrupt controller (Status/Cause/EPC, take/ERET).
// Ports:
//   i_clock, i_reset        sole rising-edge clock, asynchronous active-high reset
//   i_irq[7:0]              level interrupt lines (bit 7 = timer)
//   i_stall                 pipeline stall; blocks taking and ignores MTC0/ERET
//   i_mtc0/i_mfc0           coprocessor write/read strobes
//   i_regnum[4:0]           register select (12 Status, 13 Cause, 14 EPC)
//   i_wr_data[31:0]         MTC0 write data
//   i_eret                  exception-return strobe
//   i_next_pc[29:0]         word address saved into EPC on a take
//   o_rd_data[31:0]         MFC0 read data (combinational)
//   o_taken_interrupt       redirect fetch to the handler this cycle
//   o_epc[29:0]             saved return word address
// Build option: INT_PENDING_LATCH_EN makes Cause.IP edge-latched and software-clearable.
module int_ctrl (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_irq,
    input  logic        i_stall,
    input  logic        i_mtc0,
    input  logic        i_mfc0,
    input  logic [4:0]  i_regnum,
    input  logic [31:0] i_wr_data,
    input  logic        i_eret,
    input  logic [29:0] i_next_pc,
    output logic [31:0] o_rd_data,
    output logic        o_taken_interrupt,
    output logic [29:0] o_epc
);
    logic        r_ie;
    logic        r_exl;
    logic [7:0]  r_im;
    logic [7:0]  r_ip;
    logic [29:0] r_epc;
    logic        w_take;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_eret;

    // A stalled pipeline must not see any CP0 side effect
    assign w_wr_status = i_mtc0 & ~i_stall & (i_regnum == 5'd12);
    assign w_wr_cause  = i_mtc0 & ~i_stall & (i_regnum == 5'd13);
    assign w_wr_epc    = i_mtc0 & ~i_stall & (i_regnum == 5'd14);
    assign w_eret      = i_eret & ~i_stall;

    // Only registered state feeds the take decision, so an MTC0 acts one cycle later
    assign w_take = r_ie & ~r_exl & (|(r_ip & r_im)) & ~i_stall & ~i_eret;

    assign o_taken_interrupt = w_take;
    assign o_epc             = r_epc;

    always_comb begin
        o_rd_data = 32'd0;
        if (i_mfc0) begin
            o_rd_data = (i_regnum == 5'd12) ? {16'd0, r_im, 6'd0, r_exl, r_ie} :
                        (i_regnum == 5'd13) ? {16'd0, r_ip, 8'd0} :
                        (i_regnum == 5'd14) ? {r_epc, 2'b00} : 32'd0;
        end
    end

    // Status: software write first, ERET clears EXL, a take forces EXL last (take wins)
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
            r_im  <= 8'd0;
        end else begin
            if (w_wr_status) begin
                r_ie <= i_wr_data[0];
                r_im <= i_wr_data[15:8];
            end
            if (w_take)
                r_exl <= 1'b1;
            else if (w_eret)
                r_exl <= 1'b0;
            else if (w_wr_status)
                r_exl <= i_wr_data[1];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_epc <= 30'd0;
        else if (w_take)
            r_epc <= i_next_pc;
        else if (w_wr_epc)
            r_epc <= i_wr_data[31:2];
    end

`ifdef INT_PENDING_LATCH_EN
    logic [7:0] r_irq_q;
    logic [7:0] w_rise;

    assign w_rise = i_irq & ~r_irq_q;

    // Software may only clear pending bits; a fresh edge beats a same-cycle clear
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_irq_q <= 8'd0;
            r_ip    <= 8'd0;
        end else begin
            r_irq_q <= i_irq;
            r_ip    <= (w_wr_cause ? (r_ip & i_wr_data[15:8]) : r_ip) | w_rise;
        end
    end
`else
    logic w_unused_cause;

    assign w_unused_cause = w_wr_cause;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_ip <= 8'd0;
        else
            r_ip <= i_irq;
    end
`endif

endmodule
